// File: rtl/sample_meter_pkg.sv
// Shared types and constants for the sample period meter.
//   state_t : meter FSM encoding (IDLE, SYNC, MEASURE)
//   SAMPLE_W: width of the signed input sample stream
//   rec_t   : {period, peak} record; period is sized for the widest supported counter
package sample_meter_pkg;

   localparam int unsigned SAMPLE_W         = 8;
   localparam int unsigned REC_PERIOD_MAX_W = 16;

   typedef enum logic [1:0] {
      IDLE    = 2'd0,
      SYNC    = 2'd1,
      MEASURE = 2'd2
   } state_t;

   typedef struct packed {
      logic        [REC_PERIOD_MAX_W-1:0] period;
      logic signed [SAMPLE_W-1:0]         peak;
   } rec_t;

endpackage

// File: rtl/sample_record_reg.sv
// Single-entry output holding register for completed {period, peak} records.
//   clk, rst_n   : clock, async active-low reset
//   clr          : sync clear of the held record (overflow is kept)
//   push         : a record completes this cycle, fields on push_period/push_peak
//   rec_ready    : consumer accepts when rec_valid && rec_ready
//   rec_period, rec_peak, rec_valid : held record and its valid flag
//   overflow     : sticky, a completed record found the register still occupied
module sample_record_reg
   import sample_meter_pkg::*;
#(
   parameter int unsigned PERIOD_W = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic                       push,
   input  logic        [PERIOD_W-1:0] push_period,
   input  logic signed [SAMPLE_W-1:0] push_peak,
   input  logic                       rec_ready,
   output logic        [PERIOD_W-1:0] rec_period,
   output logic signed [SAMPLE_W-1:0] rec_peak,
   output logic                       rec_valid,
   output logic                       overflow
);

   // Free this cycle if empty or being drained by the consumer on this edge.
   logic can_load;
   assign can_load = !rec_valid || rec_ready;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rec_valid  <= 1'b0;
         rec_period <= '0;
         rec_peak   <= '0;
         overflow   <= 1'b0;
      end else if (clr) begin
         rec_valid  <= 1'b0;
         rec_period <= '0;
         rec_peak   <= '0;
      end else if (push) begin
         if (can_load) begin
            rec_valid  <= 1'b1;
            rec_period <= push_period;
            rec_peak   <= push_peak;
         end else begin
            overflow   <= 1'b1;
         end
      end else if (rec_valid && rec_ready) begin
         rec_valid <= 1'b0;
      end
   end

endmodule

// File: rtl/sample_period_meter.sv
// Measures the period (in samples) between wrap events of a signed sample
// stream and the signed peak within each period; emits one record per period.
//   clk, rst_n   : clock, async active-low reset
//   clr          : sync soft clear (keeps overflow)
//   sample_in    : signed sample, accepted when sample_valid is high
//   rec_period, rec_peak, rec_valid, rec_ready : record output handshake
//   overflow     : sticky record-dropped flag
//   state_o      : current FSM state for debug
module sample_period_meter
   import sample_meter_pkg::*;
#(
   parameter int unsigned         PERIOD_W    = 8,
   parameter logic [SAMPLE_W-1:0] DROP_THRESH = 8'd32
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       clr,
   input  logic signed [SAMPLE_W-1:0] sample_in,
   input  logic                       sample_valid,
   output logic        [PERIOD_W-1:0] rec_period,
   output logic signed [SAMPLE_W-1:0] rec_peak,
   output logic                       rec_valid,
   input  logic                       rec_ready,
   output logic                       overflow,
   output logic [1:0]                 state_o
);

   localparam logic [PERIOD_W-1:0] CNT_MAX = '1;

   state_t                     state_q, state_n;
   logic signed [SAMPLE_W-1:0] prev_q, prev_n;
   logic signed [SAMPLE_W-1:0] peak_q, peak_n;
   logic        [PERIOD_W-1:0] cnt_q, cnt_n;
   logic signed [SAMPLE_W:0]   drop;
   logic signed [SAMPLE_W:0]   thresh;
   logic                       wrap;
   logic                       push;

   // One extra bit so prev - sample never wraps (e.g. -128 - 127).
   assign drop   = {prev_q[SAMPLE_W-1], prev_q} - {sample_in[SAMPLE_W-1], sample_in};
   assign thresh = {1'b0, DROP_THRESH};
   assign wrap   = (drop >= thresh);

   always_comb begin
      state_n = state_q;
      prev_n  = prev_q;
      peak_n  = peak_q;
      cnt_n   = cnt_q;
      push    = 1'b0;
      if (clr) begin
         state_n = IDLE;
         prev_n  = '0;
         peak_n  = '0;
         cnt_n   = '0;
      end else if (sample_valid) begin
         prev_n = sample_in;
         unique case (state_q)
            IDLE: begin
               state_n = SYNC;
            end
            SYNC: begin
               if (wrap) begin
                  state_n = MEASURE;
                  cnt_n   = PERIOD_W'(1);
                  peak_n  = sample_in;
               end
            end
            MEASURE: begin
               if (wrap) begin
                  // Record carries cnt_q/peak_q, i.e. values before this sample.
                  push   = 1'b1;
                  cnt_n  = PERIOD_W'(1);
                  peak_n = sample_in;
               end else begin
                  cnt_n  = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + 1'b1;
                  peak_n = (sample_in > peak_q) ? sample_in : peak_q;
               end
            end
            default: begin
               state_n = IDLE;
            end
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q <= IDLE;
         prev_q  <= '0;
         peak_q  <= '0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_n;
         prev_q  <= prev_n;
         peak_q  <= peak_n;
         cnt_q   <= cnt_n;
      end
   end

   assign state_o = state_q;

   sample_record_reg #(
      .PERIOD_W (PERIOD_W)
   ) u_rec (
      .clk         (clk),
      .rst_n       (rst_n),
      .clr         (clr),
      .push        (push),
      .push_period (cnt_q),
      .push_peak   (peak_q),
      .rec_ready   (rec_ready),
      .rec_period  (rec_period),
      .rec_peak    (rec_peak),
      .rec_valid   (rec_valid),
      .overflow    (overflow)
   );

endmodule

// File: tb/tb_sample_period_meter.sv
// Self-checking bench for sample_period_meter: a reference model pushes expected
// records to a queue as samples are driven; tests pop and compare on output.
module tb_sample_period_meter;
   import sample_meter_pkg::*;

   logic              clk = 1'b0;
   logic              rst_n;
   logic              clr;
   logic signed [7:0] sample_in;
   logic              sample_valid;
   logic              rec_ready;

   logic        [7:0] rec_period;
   logic signed [7:0] rec_peak;
   logic              rec_valid;
   logic              overflow;
   logic        [1:0] state_o;

   logic        [3:0] rec_period4;
   logic signed [7:0] rec_peak4;
   logic              rec_valid4;
   logic              overflow4;
   logic        [1:0] state_o4;

   int errors = 0;
   int checks = 0;

   // reference model state
   int   m_state, m_prev, m_cnt, m_peak;
   rec_t exp_q[$];
   rec_t e;

   always #5 clk = ~clk;

   sample_period_meter #(.PERIOD_W(8), .DROP_THRESH(8'd32)) dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .sample_in(sample_in),
      .sample_valid(sample_valid), .rec_period(rec_period), .rec_peak(rec_peak),
      .rec_valid(rec_valid), .rec_ready(rec_ready), .overflow(overflow),
      .state_o(state_o)
   );

   sample_period_meter #(.PERIOD_W(4), .DROP_THRESH(8'd32)) dut4 (
      .clk(clk), .rst_n(rst_n), .clr(clr), .sample_in(sample_in),
      .sample_valid(sample_valid), .rec_period(rec_period4), .rec_peak(rec_peak4),
      .rec_valid(rec_valid4), .rec_ready(rec_ready), .overflow(overflow4),
      .state_o(state_o4)
   );

   task automatic model_reset();
      m_state = 0; m_prev = 0; m_cnt = 0; m_peak = 0;
      exp_q.delete();
   endtask

   task automatic model_step(input int s);
      rec_t r;
      bit   w;
      w = ((m_prev - s) >= 32);
      if (m_state == 0) begin
         m_state = 1;
      end else if (m_state == 1) begin
         if (w) begin m_state = 2; m_cnt = 1; m_peak = s; end
      end else begin
         if (w) begin
            r.period = 16'(m_cnt);
            r.peak   = 8'(m_peak);
            exp_q.push_back(r);
            m_cnt = 1; m_peak = s;
         end else begin
            if (m_cnt < 255) m_cnt++;
            if (s > m_peak) m_peak = s;
         end
      end
      m_prev = s;
   endtask

   task automatic feed(input int s);
      sample_in    = 8'(s);
      sample_valid = 1'b1;
      @(posedge clk); #1;
      model_step(s);
   endtask

   task automatic idle_cycle();
      sample_valid = 1'b0;
      @(posedge clk); #1;
   endtask

   task automatic pop_exp();
      if (exp_q.size() == 0) begin
         errors++;
         $display("FAIL scoreboard_empty got 0 entries want >=1");
         e = '0;
      end else begin
         e = exp_q.pop_front();
      end
   endtask

   task automatic test_reset();
      rst_n = 1'b0; clr = 1'b0; sample_in = '0; sample_valid = 1'b0; rec_ready = 1'b0;
      model_reset();
      #12;
      checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", rec_valid); end
      checks++; if (rec_period !== 8'd0) begin errors++; $display("FAIL reset_period got %0d want 0", rec_period); end
      checks++; if (rec_peak !== 8'sd0) begin errors++; $display("FAIL reset_peak got %0d want 0", rec_peak); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow got %0b want 0", overflow); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL reset_state got %0d want 0", state_o); end
      #1 rst_n = 1'b1;
      @(posedge clk); #1;
   endtask

   task automatic test_basic();
      int v[12] = '{0, 10, 20, 30, 40, 50, -20, 0, 20, 40, 60, -20};
      rec_ready = 1'b1;
      for (int i = 0; i < 12; i++) begin
         feed(v[i]);
         if (i == 6) begin
            checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL basic_sync_to_measure got %0d want 2", state_o); end
            checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL basic_no_partial got %0b want 0", rec_valid); end
         end
      end
      pop_exp();
      checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL basic_valid got %0b want 1", rec_valid); end
      checks++; if (rec_period !== e.period[7:0]) begin errors++; $display("FAIL basic_period got %0d want %0d", rec_period, e.period); end
      checks++; if (rec_peak !== e.peak) begin errors++; $display("FAIL basic_peak got %0d want %0d", rec_peak, e.peak); end
      idle_cycle();
      checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL basic_drain got %0b want 0", rec_valid); end
   endtask

   task automatic test_backpressure();
      int v[8] = '{0, 20, 40, 60, -20, 0, 10, -30};
      rec_ready = 1'b0;
      foreach (v[i]) feed(v[i]);
      pop_exp();
      checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL bp_valid got %0b want 1", rec_valid); end
      checks++; if (rec_period !== e.period[7:0]) begin errors++; $display("FAIL bp_held_period got %0d want %0d", rec_period, e.period); end
      checks++; if (rec_peak !== e.peak) begin errors++; $display("FAIL bp_held_peak got %0d want %0d", rec_peak, e.peak); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow got %0b want 1", overflow); end
      pop_exp(); // second record is dropped by the DUT
      rec_ready = 1'b1;
      idle_cycle();
      rec_ready = 1'b0;
      checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL bp_after_accept got %0b want 0", rec_valid); end
      checks++; if (overflow !== 1'b1) begin errors++; $display("FAIL bp_overflow_sticky got %0b want 1", overflow); end
   endtask

   task automatic test_simultaneous();
      int v[6] = '{0, 50, -10, 5, 15, -40};
      #1 rst_n = 1'b0;
      #2 rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sim_overflow_reset got %0b want 0", overflow); end
      rec_ready = 1'b0;
      foreach (v[i]) feed(v[i]);
      pop_exp();
      checks++; if (rec_period !== e.period[7:0] || rec_valid !== 1'b1) begin errors++; $display("FAIL sim_first_rec got %0d/%0b want %0d/1", rec_period, rec_valid, e.period); end
      feed(0);
      feed(30);
      checks++; if (rec_peak !== e.peak) begin errors++; $display("FAIL sim_held_peak got %0d want %0d", rec_peak, e.peak); end
      rec_ready = 1'b1;
      feed(-10);
      pop_exp();
      checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL sim_valid got %0b want 1", rec_valid); end
      checks++; if (rec_period !== e.period[7:0]) begin errors++; $display("FAIL sim_period got %0d want %0d", rec_period, e.period); end
      checks++; if (rec_peak !== e.peak) begin errors++; $display("FAIL sim_peak got %0d want %0d", rec_peak, e.peak); end
      checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL sim_overflow got %0b want 0", overflow); end
      idle_cycle();
      checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL sim_drain got %0b want 0", rec_valid); end
   endtask

   task automatic test_threshold();
      int v[5] = '{-50, -70, -90, -110, -128};
      rec_ready = 1'b1;
      feed(10);
      feed(-21);
      checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL thr_drop31 got %0b want 0", rec_valid); end
      feed(10);
      feed(-22);
      pop_exp();
      checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL thr_drop32 got %0b want 1", rec_valid); end
      checks++; if (rec_period !== e.period[7:0]) begin errors++; $display("FAIL thr_period got %0d want %0d", rec_period, e.period); end
      foreach (v[i]) feed(v[i]);
      feed(127);
      checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL thr_neg_to_pos got %0b want 0", rec_valid); end
      feed(-128);
      pop_exp();
      checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL thr_drop255 got %0b want 1", rec_valid); end
      checks++; if (rec_period !== e.period[7:0]) begin errors++; $display("FAIL thr_period2 got %0d want %0d", rec_period, e.period); end
      checks++; if (rec_peak !== e.peak) begin errors++; $display("FAIL thr_peak2 got %0d want %0d", rec_peak, e.peak); end
   endtask

   task automatic test_saturation();
      rec_ready = 1'b1;
      for (int i = 1; i <= 20; i++) feed(-128 + i * 5);
      feed(-100);
      pop_exp();
      checks++; if (rec_period !== e.period[7:0]) begin errors++; $display("FAIL sat_w8_period got %0d want %0d", rec_period, e.period); end
      checks++; if (rec_valid4 !== 1'b1) begin errors++; $display("FAIL sat_w4_valid got %0b want 1", rec_valid4); end
      checks++; if (rec_period4 !== 4'd15) begin errors++; $display("FAIL sat_w4_period got %0d want 15", rec_period4); end
      checks++; if (rec_peak4 !== -8'sd28) begin errors++; $display("FAIL sat_w4_peak got %0d want -28", rec_peak4); end
   endtask

   task automatic test_reset_clear();
      rec_ready = 1'b0;
      feed(0);
      feed(-50);
      checks++; if (rec_valid !== 1'b1) begin errors++; $display("FAIL rst_pre_valid got %0b want 1", rec_valid); end
      sample_valid = 1'b0;
      #1 rst_n = 1'b0;
      #1;
      checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL rst_async_valid got %0b want 0", rec_valid); end
      checks++; if (rec_period !== 8'd0) begin errors++; $display("FAIL rst_async_period got %0d want 0", rec_period); end
      checks++; if (rec_peak !== 8'sd0) begin errors++; $display("FAIL rst_async_peak got %0d want 0", rec_peak); end
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL rst_async_state got %0d want 0", state_o); end
      #1 rst_n = 1'b1;
      model_reset();
      @(posedge clk); #1;
      feed(0);
      feed(50);
      feed(-10);
      checks++; if (state_o !== 2'd2) begin errors++; $display("FAIL clr_pre_state got %0d want 2", state_o); end
      sample_in    = -8'sd100;
      sample_valid = 1'b1;
      clr          = 1'b1;
      @(posedge clk); #1;
      clr = 1'b0;
      model_reset();
      checks++; if (state_o !== 2'd0) begin errors++; $display("FAIL clr_state got %0d want 0", state_o); end
      checks++; if (rec_valid !== 1'b0) begin errors++; $display("FAIL clr_valid got %0b want 0", rec_valid); end
      feed(40);
      checks++; if (state_o !== 2'd1) begin errors++; $display("FAIL clr_sample_ignored got %0d want 1", state_o); end
      sample_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_basic();
      test_backpressure();
      test_simultaneous();
      test_threshold();
      test_saturation();
      test_reset_clear();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout got running want finished");
      $fatal(1);
   end

endmodule
